// File: rtl/python_align.sv
// python_align: per-lane word alignment and training calibration for the
// PYTHON300 LVDS receive path. Each lane scans bit offsets 0..WORD_BITS-1 of
// its deserialized stream for the training word, locks the first offset that
// matches MATCH_COUNT times in a row, and then emits word-aligned data.
//
// Handshake: in_valid is a pure strobe with no backpressure. A word is
// accepted on every rising clk edge where in_valid is high. out_valid is
// in_valid delayed by one cycle, and out_data is updated only on those cycles.
// Lane FSM state is kept in lane_state[] so checkers can bind to it directly.
module python_align #(
  parameter int CHANNELS     = 4,
  parameter int WORD_BITS    = 10,
  parameter int SETTLE_WORDS = 4,
  parameter int MATCH_COUNT  = 16,
  parameter int OFFSET_BITS  = $clog2(WORD_BITS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_align_reset,
  input  logic [WORD_BITS-1:0]            in_align_pattern,
  input  logic                            in_valid,
  input  logic [CHANNELS*WORD_BITS-1:0]   in_data,
  output logic                            out_valid,
  output logic [CHANNELS*WORD_BITS-1:0]   out_data,
  output logic [CHANNELS*OFFSET_BITS-1:0] out_bitslip,
  output logic                            out_calib_done,
  output logic                            out_calib_error
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } lane_state_t;

  // +1 so a count equal to the parameter itself still fits.
  localparam int SETTLE_CW = $clog2(SETTLE_WORDS + 1);
  localparam int MATCH_CW  = $clog2(MATCH_COUNT + 1);

  localparam logic [SETTLE_CW-1:0]   SETTLE_LAST = SETTLE_CW'(SETTLE_WORDS - 1);
  localparam logic [MATCH_CW-1:0]    MATCH_LAST  = MATCH_CW'(MATCH_COUNT - 1);
  localparam logic [OFFSET_BITS-1:0] OFFSET_LAST = OFFSET_BITS'(WORD_BITS - 1);

  lane_state_t            lane_state    [CHANNELS];
  lane_state_t            lane_state_nx [CHANNELS];
  logic [OFFSET_BITS-1:0] offset        [CHANNELS];
  logic [OFFSET_BITS-1:0] offset_nx     [CHANNELS];
  logic [SETTLE_CW-1:0]   settle_cnt    [CHANNELS];
  logic [SETTLE_CW-1:0]   settle_cnt_nx [CHANNELS];
  logic [MATCH_CW-1:0]    match_cnt     [CHANNELS];
  logic [MATCH_CW-1:0]    match_cnt_nx  [CHANNELS];
  logic [WORD_BITS-1:0]   prev          [CHANNELS];
  logic [WORD_BITS-1:0]   aligned       [CHANNELS];
  logic [2*WORD_BITS-1:0] window;
  logic                   all_locked;
  logic                   any_fail;
  logic                   restart;

  assign restart = reset | in_align_reset;

  // Previous raw word per lane; keeps loading through restart so the window
  // is already primed when calibration is released.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_valid) prev[i] <= in_data[i*WORD_BITS +: WORD_BITS];
    end
  end

  // Window select and per-lane search FSM next state; everything holds
  // while in_valid is low.
  always_comb begin
    window     = '0;
    all_locked = 1'b1;
    any_fail   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      window     = {in_data[i*WORD_BITS +: WORD_BITS], prev[i]};
      aligned[i] = WORD_BITS'(window >> offset[i]);

      lane_state_nx[i] = lane_state[i];
      offset_nx[i]     = offset[i];
      settle_cnt_nx[i] = settle_cnt[i];
      match_cnt_nx[i]  = match_cnt[i];

      if (lane_state[i] != ST_LOCKED) all_locked = 1'b0;
      if (lane_state[i] == ST_FAIL)   any_fail   = 1'b1;

      if (in_valid) begin
        unique case (lane_state[i])
          ST_SETTLE: begin
            if (settle_cnt[i] == SETTLE_LAST) begin
              lane_state_nx[i] = ST_CHECK;
              settle_cnt_nx[i] = '0;
              match_cnt_nx[i]  = '0;
            end else begin
              settle_cnt_nx[i] = settle_cnt[i] + SETTLE_CW'(1);
            end
          end
          ST_CHECK: begin
            if (aligned[i] == in_align_pattern) begin
              if (match_cnt[i] == MATCH_LAST) begin
                lane_state_nx[i] = ST_LOCKED;
              end else begin
                match_cnt_nx[i] = match_cnt[i] + MATCH_CW'(1);
              end
            end else if (offset[i] != OFFSET_LAST) begin
              // Try the next bit offset after letting the window settle.
              offset_nx[i]     = offset[i] + OFFSET_BITS'(1);
              settle_cnt_nx[i] = '0;
              match_cnt_nx[i]  = '0;
              lane_state_nx[i] = ST_SETTLE;
            end else begin
              // Last offset also mismatched: give up, offset stays put.
              lane_state_nx[i] = ST_FAIL;
            end
          end
          ST_LOCKED: lane_state_nx[i] = ST_LOCKED;
          ST_FAIL:   lane_state_nx[i] = ST_FAIL;
          default:   lane_state_nx[i] = ST_SETTLE;
        endcase
      end
    end
  end

  // Lane FSM registers; restart pins every lane to SETTLE at offset 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (restart) begin
        lane_state[i] <= ST_SETTLE;
        offset[i]     <= '0;
        settle_cnt[i] <= '0;
        match_cnt[i]  <= '0;
      end else begin
        lane_state[i] <= lane_state_nx[i];
        offset[i]     <= offset_nx[i];
        settle_cnt[i] <= settle_cnt_nx[i];
        match_cnt[i]  <= match_cnt_nx[i];
      end
    end
  end

  // Registered calibration status, sampled from the current lane states.
  always_ff @(posedge clk) begin
    if (restart) begin
      out_calib_done  <= 1'b0;
      out_calib_error <= 1'b0;
    end else begin
      out_calib_done  <= all_locked;
      out_calib_error <= any_fail;
    end
  end

  // Aligned data path; runs in every lane state.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_valid) out_data[i*WORD_BITS +: WORD_BITS] <= aligned[i];
      end
    end
  end

  // Current offsets, packed like the data buses.
  always_comb begin
    out_bitslip = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out_bitslip[i*OFFSET_BITS +: OFFSET_BITS] = offset[i];
    end
  end

endmodule
